// File: rtl/video_timing_gen_if.sv
// Raster timing bundle from the timing generator to its consumers
// (pixel fetch/render, DVI/VGA output, scanline status read).
interface video_timing_gen_if;
    logic [10:0] h_count_o;
    logic [10:0] v_count_o;
    logic        hsync_o;
    logic        vsync_o;
    logic        h_blank_o;
    logic        v_blank_o;
    logic        dv_de_o;
    logic        end_of_line_o;
    logic        end_of_frame_o;
    logic [15:0] scanline_o;

    modport master (
        output h_count_o, v_count_o, hsync_o, vsync_o, h_blank_o, v_blank_o,
               dv_de_o, end_of_line_o, end_of_frame_o, scanline_o
    );

    modport slave (
        input  h_count_o, v_count_o, hsync_o, vsync_o, h_blank_o, v_blank_o,
               dv_de_o, end_of_line_o, end_of_frame_o, scanline_o
    );
endinterface

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: pixel/line counters with sync, blank,
// display-enable and line/frame strobes, all registered and mutually aligned.
module video_timing_gen #(
    parameter int unsigned VISIBLE_WIDTH   = 640,
    parameter int unsigned VISIBLE_HEIGHT  = 480,
    parameter int unsigned H_FRONT_PORCH   = 16,
    parameter int unsigned H_SYNC_PULSE    = 96,
    parameter int unsigned H_BACK_PORCH    = 48,
    parameter int unsigned V_FRONT_PORCH   = 10,
    parameter int unsigned V_SYNC_PULSE    = 2,
    parameter int unsigned V_BACK_PORCH    = 33,
    parameter logic        H_SYNC_POLARITY = 1'b0,
    parameter logic        V_SYNC_POLARITY = 1'b0
) (
    input  logic                clk,
    input  logic                reset_i,
    video_timing_gen_if.master  vid
);

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned TOTAL_W = VISIBLE_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int unsigned TOTAL_H = VISIBLE_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

    // Window bounds expressed as inclusive last indices so they always fit CNT_W
    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(TOTAL_W - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(TOTAL_H - 1);
    localparam logic [CNT_W-1:0] H_VIS_LAST   = CNT_W'(VISIBLE_WIDTH - 1);
    localparam logic [CNT_W-1:0] V_VIS_LAST   = CNT_W'(VISIBLE_HEIGHT - 1);
    localparam logic [CNT_W-1:0] H_SYNC_FIRST = CNT_W'(VISIBLE_WIDTH + H_FRONT_PORCH);
    localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(VISIBLE_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE - 1);
    localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(VISIBLE_HEIGHT + V_FRONT_PORCH);
    localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(VISIBLE_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE - 1);

    generate
        if (TOTAL_W > 2048 || TOTAL_H > 2048) begin : g_bad_timing
            $error("video_timing_gen: total raster exceeds 2048 in one dimension");
        end
    endgenerate

    logic [CNT_W-1:0] h_q, v_q;
    logic             hsync_q, vsync_q, h_blank_q, v_blank_q, de_q, eol_q, eof_q;

    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic             h_last, v_last;
    logic             hsync_nxt, vsync_nxt, h_blank_nxt, v_blank_nxt, de_nxt, eol_nxt, eof_nxt;

    // Flags are decoded from the next position so they land with the counters
    always_comb begin
        h_last      = (h_q == H_LAST);
        v_last      = (v_q == V_LAST);
        h_nxt       = h_last ? '0 : h_q + CNT_W'(1);
        v_nxt       = v_q;
        if (h_last) begin
            v_nxt = v_last ? '0 : v_q + CNT_W'(1);
        end
        h_blank_nxt = (h_nxt > H_VIS_LAST);
        v_blank_nxt = (v_nxt > V_VIS_LAST);
        de_nxt      = !h_blank_nxt && !v_blank_nxt;
        hsync_nxt   = (h_nxt >= H_SYNC_FIRST && h_nxt <= H_SYNC_LAST) ? H_SYNC_POLARITY
                                                                      : ~H_SYNC_POLARITY;
        vsync_nxt   = (v_nxt >= V_SYNC_FIRST && v_nxt <= V_SYNC_LAST) ? V_SYNC_POLARITY
                                                                      : ~V_SYNC_POLARITY;
        eol_nxt     = (h_nxt == H_LAST);
        eof_nxt     = eol_nxt && (v_nxt == V_LAST);
    end

    // Reset parks at the last pixel of the frame so the first live edge wraps to (0,0)
    always_ff @(posedge clk) begin
        if (reset_i) begin
            h_q       <= H_LAST;
            v_q       <= V_LAST;
            hsync_q   <= ~H_SYNC_POLARITY;
            vsync_q   <= ~V_SYNC_POLARITY;
            h_blank_q <= 1'b1;
            v_blank_q <= 1'b1;
            de_q      <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
        end else begin
            h_q       <= h_nxt;
            v_q       <= v_nxt;
            hsync_q   <= hsync_nxt;
            vsync_q   <= vsync_nxt;
            h_blank_q <= h_blank_nxt;
            v_blank_q <= v_blank_nxt;
            de_q      <= de_nxt;
            eol_q     <= eol_nxt;
            eof_q     <= eof_nxt;
        end
    end

    assign vid.h_count_o      = h_q;
    assign vid.v_count_o      = v_q;
    assign vid.hsync_o        = hsync_q;
    assign vid.vsync_o        = vsync_q;
    assign vid.h_blank_o      = h_blank_q;
    assign vid.v_blank_o      = v_blank_q;
    assign vid.dv_de_o        = de_q;
    assign vid.end_of_line_o  = eol_q;
    assign vid.end_of_frame_o = eof_q;
    assign vid.scanline_o     = {v_blank_q, h_blank_q, 3'b000, v_q};

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: small-raster generator (both sync polarities) and the default
// 640x480 mode, checked cycle by cycle plus directed raster properties.
module tb_video_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        de;
        logic        eol;
        logic        eof;
        logic [15:0] sl;
    } vt_t;

    typedef struct {
        vt_t s;
        vt_t p;
        vt_t d;
        bit  rs;
        bit  rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_s = 1'b1;
    logic rst_d = 1'b1;
    always #5 clk = ~clk;

    video_timing_gen_if s_if ();
    video_timing_gen_if p_if ();
    video_timing_gen_if d_if ();

    video_timing_gen #(
        .VISIBLE_WIDTH(8), .VISIBLE_HEIGHT(4), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3),
        .H_BACK_PORCH(1), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
        .H_SYNC_POLARITY(1'b0), .V_SYNC_POLARITY(1'b0)
    ) u_small (.clk(clk), .reset_i(rst_s), .vid(s_if));

    video_timing_gen #(
        .VISIBLE_WIDTH(8), .VISIBLE_HEIGHT(4), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3),
        .H_BACK_PORCH(1), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
        .H_SYNC_POLARITY(1'b1), .V_SYNC_POLARITY(1'b1)
    ) u_pol (.clk(clk), .reset_i(rst_s), .vid(p_if));

    video_timing_gen u_def (.clk(clk), .reset_i(rst_d), .vid(d_if));

    vt_t act_s, act_p, act_d;
    assign act_s = {s_if.h_count_o, s_if.v_count_o, s_if.hsync_o, s_if.vsync_o, s_if.h_blank_o,
                    s_if.v_blank_o, s_if.dv_de_o, s_if.end_of_line_o, s_if.end_of_frame_o, s_if.scanline_o};
    assign act_p = {p_if.h_count_o, p_if.v_count_o, p_if.hsync_o, p_if.vsync_o, p_if.h_blank_o,
                    p_if.v_blank_o, p_if.dv_de_o, p_if.end_of_line_o, p_if.end_of_frame_o, p_if.scanline_o};
    assign act_d = {d_if.h_count_o, d_if.v_count_o, d_if.hsync_o, d_if.vsync_o, d_if.h_blank_o,
                    d_if.v_blank_o, d_if.dv_de_o, d_if.end_of_line_o, d_if.end_of_frame_o, d_if.scanline_o};

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int exp_eof_s = 0;
    int exp_eol_d = 0;
    int seen_eof_s = 0;
    int seen_eol_d = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
        end
    endtask

    // Reference raster decode from the mode constants
    function automatic vt_t model(input int h, input int v, input int vw, input int hfp,
                                  input int hsw, input int hbp, input int vh, input int vfp,
                                  input int vsw, input int vbp, input bit pol, input bit rst);
        vt_t o;
        int tw = vw + hfp + hsw + hbp;
        int th = vh + vfp + vsw + vbp;
        o.h   = 11'(h);
        o.v   = 11'(v);
        o.hb  = (h >= vw);
        o.vb  = (v >= vh);
        o.de  = !o.hb && !o.vb;
        o.hs  = (!rst && h >= vw + hfp && h < vw + hfp + hsw) ? pol : ~pol;
        o.vs  = (!rst && v >= vh + vfp && v < vh + vfp + vsw) ? pol : ~pol;
        o.eol = !rst && (h == tw - 1);
        o.eof = o.eol && (v == th - 1);
        o.sl  = {o.vb, o.hb, 3'b000, o.v};
        return o;
    endfunction

    int sh = 13, sv = 7, dh = 799, dv = 524;

    task automatic step(input bit rs, input bit rd);
        exp_t e;
        @(negedge clk);
        rst_s = rs;
        rst_d = rd;
        if (rs) begin
            sh = 13; sv = 7;
        end else if (sh == 13) begin
            sh = 0; sv = (sv == 7) ? 0 : sv + 1;
        end else begin
            sh++;
        end
        if (rd) begin
            dh = 799; dv = 524;
        end else if (dh == 799) begin
            dh = 0; dv = (dv == 524) ? 0 : dv + 1;
        end else begin
            dh++;
        end
        e.s  = model(sh, sv, 8, 2, 3, 1, 4, 1, 2, 1, 1'b0, rs);
        e.p  = model(sh, sv, 8, 2, 3, 1, 4, 1, 2, 1, 1'b1, rs);
        e.d  = model(dh, dv, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, rd);
        e.rs = rs;
        e.rd = rd;
        if (e.s.eof) exp_eof_s++;
        if (e.d.eol) exp_eol_d++;
        q.push_back(e);
    endtask

    // Monitor: pops one expected record per clock and checks the live outputs
    initial begin
        exp_t e;
        bit   prev_rs = 1'b1;
        bit   prev_hs_d = 1'b1;
        int   gap = 0, vlow = 0, hlow_s = 0, hlow_d = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("small_pol0", act_s, e.s);
                chk("small_pol1", act_p, e.p);
                chk("default_mode", act_d, e.d);
                if (prev_rs && !e.rs) begin
                    chk("release_pol0", {act_s.h, act_s.v, act_s.de, act_s.hs, act_s.vs},
                        {11'd0, 11'd0, 1'b1, 1'b1, 1'b1});
                    chk("release_pol1", {act_p.hs, act_p.vs}, 2'b00);
                end
                if (e.s.h == 11'd13 && e.s.v == 11'd7) chk("scanline_c007", act_s.sl, 16'hC007);
                if (e.rs) begin
                    chk("eol_in_reset", {act_s.eol, act_s.eof}, 2'b00);
                    gap = 0; vlow = 0; hlow_s = 0;
                end else begin
                    gap++;
                    if (!act_s.vs) vlow++;
                    if (!act_s.hs) hlow_s++;
                    if (act_s.eol) begin
                        chk("hsync_low_per_line", hlow_s, 3);
                        hlow_s = 0;
                    end
                    if (act_s.eof) begin
                        seen_eof_s++;
                        chk("eof_period", gap, 112);
                        chk("vsync_low_per_frame", vlow, 28);
                        gap = 0; vlow = 0;
                    end
                end
                if (e.rd) begin
                    hlow_d = 0;
                end else begin
                    if (!act_d.hs) hlow_d++;
                    if (prev_hs_d && !act_d.hs) chk("default_hsync_start", act_d.h, 656);
                    if (act_d.eol) begin
                        seen_eol_d++;
                        chk("default_hsync_width", hlow_d, 96);
                        hlow_d = 0;
                    end
                end
                prev_hs_d = act_d.hs;
                prev_rs   = e.rs;
            end
        end
    end

    // Stimulus: reset 3 cycles, run frames, reset pulse at (5,2), run again
    initial begin
        bit pulsed = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            if (!pulsed && i > 230 && sh == 4 && sv == 2) begin
                // position after this edge is (5,2); reset on the following edge
                step(1'b0, 1'b0);
                step(1'b1, 1'b0);
                pulsed = 1'b1;
            end else begin
                step(1'b0, 1'b0);
            end
        end
        @(posedge clk);
        #2;
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("reset_pulse_hit", 64'(pulsed), 64'd1);
        chk("eof_count", seen_eof_s, exp_eof_s);
        chk("default_eol_count", seen_eol_d, exp_eol_d);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates raster timing for the video output path from the mode timing constants (visible size, porches, sync widths, polarities).
- Produces pixel/line counters, H/V sync, blank and display-enable flags, and line/frame strobes.
- Downstream consumers are the pixel fetch/render stage, the DVI/VGA output, and the AUX_VID_R_SCANLINE read value.

Parameters:
- VISIBLE_WIDTH, 640, active pixels per line
- VISIBLE_HEIGHT, 480, active lines per frame
- H_FRONT_PORCH, 16, pixels between visible end and hsync start
- H_SYNC_PULSE, 96, hsync width in pixels
- H_BACK_PORCH, 48, pixels after hsync before next line
- V_FRONT_PORCH, 10, lines between visible end and vsync start
- V_SYNC_PULSE, 2, vsync width in lines
- V_BACK_PORCH, 33, lines after vsync before next frame
- H_SYNC_POLARITY, 1'b0, active level of hsync_o
- V_SYNC_POLARITY, 1'b0, active level of vsync_o

Ports:
- clk  in  1  pixel clock; one clock domain only
- reset_i  in  1  synchronous, active-high reset
- h_count_o  out  11  current pixel column
- v_count_o  out  11  current line
- hsync_o  out  1  horizontal sync, polarity per H_SYNC_POLARITY
- vsync_o  out  1  vertical sync, polarity per V_SYNC_POLARITY
- h_blank_o  out  1  high when h_count_o >= VISIBLE_WIDTH
- v_blank_o  out  1  high when v_count_o >= VISIBLE_HEIGHT
- dv_de_o  out  1  display enable = !h_blank_o && !v_blank_o
- end_of_line_o  out  1  one-cycle strobe at last pixel of each line
- end_of_frame_o  out  1  one-cycle strobe at last pixel of last line
- scanline_o  out  16  {v_blank, h_blank, 3'b000, v_count[10:0]}

Behaviour:
- Derived constants:
  - TOTAL_W = VISIBLE_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH
  - TOTAL_H is the vertical equivalent.
  - Both must be <= 2048. An elaboration-time check fails otherwise.
- Column order within a line:
  - visible: 0..VISIBLE_WIDTH-1
  - front porch: VISIBLE_WIDTH..VISIBLE_WIDTH+HFP-1
  - sync: VISIBLE_WIDTH+HFP..VISIBLE_WIDTH+HFP+HS-1
  - back porch: remaining columns to TOTAL_W-1
- Line order within a frame follows the same visible / front porch / sync / back porch pattern.
- All outputs are registered and mutually consistent in the same cycle, i.e. flags describe the h/v values currently on h_count_o/v_count_o. Zero latency between counter and flags.
- Counter advance, every clock when not in reset:
  - h = (h == TOTAL_W-1) ? 0 : h+1
  - v advances only when h == TOTAL_W-1: v = (v == TOTAL_H-1) ? 0 : v+1
- Sync outputs:
  - hsync_o is at active level when h is in the H sync window; otherwise ~H_SYNC_POLARITY.
  - vsync_o is at active level for all pixels of lines in the V sync window. It changes at the line boundary, together with v.
- Strobes:
  - end_of_line_o = (h == TOTAL_W-1)
  - end_of_frame_o = (h == TOTAL_W-1) && (v == TOTAL_H-1)
- Reset state:
  - counters h = TOTAL_W-1, v = TOTAL_H-1
  - h_blank_o = v_blank_o = 1, dv_de_o = 0
  - syncs at inactive level
  - end_of_line_o = end_of_frame_o = 0 (suppressed for the reset-derived position)
  - scanline_o = {1,1,000,TOTAL_H-1}
- First clock edge after reset_i deasserts: counters go to (0,0) and dv_de_o = 1.
- Reset asserted mid-frame: the next edge loads the reset state unconditionally. No partial line is emitted afterwards.
- No other inputs exist; the block free-runs.

Test Plan:
- Small params (VW=8, HFP=2, HS=3, HBP=1, VH=4, VFP=1, VS=2, VBP=1, both polarities 0): hold reset 3 cycles, release -> first edge h=0, v=0, dv_de_o=1, hsync_o=1, vsync_o=1; end_of_line_o stayed 0 during reset.
- Same params, line 0 -> dv_de_o high h=0..7; h_blank_o high h=8..13; hsync_o=0 exactly h=10..12; end_of_line_o pulses only at h=13; h wraps to 0 and v=1 on the next edge.
- Same params, full frame -> exactly 112 cycles between end_of_frame_o pulses; vsync_o=0 exactly on lines 5..6 (28 cycles); v_blank_o high on lines 4..7; scanline_o = 0xC007 at h=13, v=7.
- Polarity 1 for both -> hsync_o/vsync_o inverted relative to the previous cases at every cycle; counters identical.
- Reset pulse at h=5, v=2 -> next cycle shows the reset state (h=13, v=7, dv_de_o=0, no strobe); after release the frame restarts at (0,0).
- Default 640x480 params -> end_of_frame_o period 800*525 = 420000 cycles; hsync low h=656..751; vsync low v=490..491.
